// File: rtl/openram_pkg.sv
// Shared types and sizing helpers for the OpenRAM bank controller family.
// Helpers are functions so each instance can size itself from its own parameters.
package openram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } ctrl_state_e;

  function automatic int byteOffBitsOf(input int dataWidth);
    return (dataWidth > 8) ? $clog2(dataWidth / 8) : 0;
  endfunction

  // A single bank needs no select bits; callers still size the bank port to at least one bit.
  function automatic int bankSelBitsOf(input int bankCount);
    return (bankCount > 1) ? $clog2(bankCount) : 0;
  endfunction

  localparam int ByteOffBits = byteOffBitsOf(32);
  localparam int BankSelBits = bankSelBitsOf(4);

endpackage

// File: rtl/openram_addr_decode.sv
// Combinational byte-address decode into interleaved bank, macro row and error flag.
// Misaligned addresses and word indices beyond bank+row bits are flagged as errors.
module openram_addr_decode
  import openram_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int BankCount     = 4,
  parameter int BankAddrWidth = 8,
  localparam int ByteOff      = byteOffBitsOf(DataWidth),
  localparam int SelBits      = bankSelBitsOf(BankCount),
  localparam int SelW         = (SelBits > 0) ? SelBits : 1
) (
  input  logic [AddrWidth-1:0]     reqAddr,
  output logic [SelW-1:0]          bank,
  output logic [BankAddrWidth-1:0] row,
  output logic                     err
);

  logic [AddrWidth-1:0] wordIdx;
  logic [AddrWidth-1:0] lowMask;
  logic [AddrWidth-1:0] highIdx;

  assign wordIdx = reqAddr >> ByteOff;
  assign lowMask = AddrWidth'((64'd1 << ByteOff) - 64'd1);
  assign highIdx = wordIdx >> (SelBits + BankAddrWidth);
  assign row     = wordIdx[SelBits +: BankAddrWidth];
  assign err     = (|(reqAddr & lowMask)) || (|highIdx);

  generate
    if (SelBits > 0) begin : g_multi_bank
      assign bank = wordIdx[SelW-1:0];
    end else begin : g_single_bank
      assign bank = '0;
    end
  endgenerate

endmodule

// File: rtl/openram_bank_ctrl.sv
// Valid/ready request controller for an interleaved array of OpenRAM single-port macros.
// One request outstanding; every macro strobe and shared bus signal is a register output.
module openram_bank_ctrl
  import openram_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int BankCount     = 4,
  parameter int BankAddrWidth = 8,
  parameter int ReadLatency   = 1
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic                           reqWrite,
  input  logic [AddrWidth-1:0]           reqAddr,
  input  logic [DataWidth-1:0]           reqWData,
  input  logic [DataWidth/8-1:0]         reqWMask,
  output logic                           respValid,
  input  logic                           respReady,
  output logic [DataWidth-1:0]           respRData,
  output logic                           respErr,
  output logic [BankAddrWidth-1:0]       sramAddr,
  output logic [DataWidth-1:0]           sramDataIn,
  output logic [DataWidth/8-1:0]         sramWMask,
  output logic [BankCount-1:0]           sramCsB,
  output logic                           sramWeB,
  output logic                           sramOeB,
  input  logic [BankCount*DataWidth-1:0] sramDataOut
);

  localparam int SelBits = bankSelBitsOf(BankCount);
  localparam int SelW    = (SelBits > 0) ? SelBits : 1;
  localparam int CntW    = $clog2(ReadLatency + 1);

  ctrl_state_e state, nextState;

  logic [SelW-1:0]          decBank;
  logic [BankAddrWidth-1:0] decRow;
  logic                     decErr;

  logic [SelW-1:0]      bankReg;
  logic                 writeReg;
  logic [CntW-1:0]      waitCnt;
  logic [BankCount-1:0] nextCsB;
  logic                 nextWeB;
  logic                 nextOeB;

  openram_addr_decode #(
    .DataWidth    (DataWidth),
    .AddrWidth    (AddrWidth),
    .BankCount    (BankCount),
    .BankAddrWidth(BankAddrWidth)
  ) u_decode (
    .reqAddr(reqAddr),
    .bank   (decBank),
    .row    (decRow),
    .err    (decErr)
  );

  assign reqReady = (state == IDLE);

  // Strobe values are computed for the upcoming state and registered, so the
  // macros never see a combinational path from the client request.
  always_comb begin
    nextState = state;
    nextCsB   = '1;
    nextWeB   = 1'b1;
    nextOeB   = 1'b1;
    case (state)
      IDLE: begin
        if (reqValid) begin
          if (decErr || (reqWrite && (reqWMask == '0))) begin
            nextState = RESP;
          end else begin
            nextState = ACCESS;
            nextCsB   = ~(BankCount'(1) << decBank);
            nextWeB   = ~reqWrite;
            nextOeB   = reqWrite;
          end
        end
      end
      ACCESS: begin
        if (writeReg) begin
          nextState = RESP;
        end else begin
          nextState = WAIT;
          nextOeB   = 1'b0;
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          nextState = RESP;
        end else begin
          nextOeB = 1'b0;
        end
      end
      RESP: begin
        if (respReady) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      sramCsB    <= '1;
      sramWeB    <= 1'b1;
      sramOeB    <= 1'b1;
      sramAddr   <= '0;
      sramDataIn <= '0;
      sramWMask  <= '0;
      respValid  <= 1'b0;
      respErr    <= 1'b0;
      respRData  <= '0;
      bankReg    <= '0;
      writeReg   <= 1'b0;
      waitCnt    <= '0;
    end else begin
      state     <= nextState;
      sramCsB   <= nextCsB;
      sramWeB   <= nextWeB;
      sramOeB   <= nextOeB;
      respValid <= (nextState == RESP);
      case (state)
        IDLE: begin
          if (reqValid) begin
            bankReg   <= decBank;
            writeReg  <= reqWrite;
            respErr   <= decErr;
            respRData <= '0;
            if (!decErr) begin
              sramAddr   <= decRow;
              sramDataIn <= reqWData;
              sramWMask  <= reqWMask;
            end
          end
        end
        ACCESS: waitCnt <= CntW'(ReadLatency - 1);
        WAIT: begin
          if (waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
          end else begin
            respRData <= sramDataOut[bankReg*DataWidth +: DataWidth];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
